fix_field_extractor: RTL and testbench

Field-level framing stage directly downstream of the FIX byte-delimiter detector. Each cycle it takes a 32-bit stream word together with the detector's SOH (0x01) and '=' (0x3D) byte indices. It splits the stream into tag/value fields, converts the ASCII tag to binary, and forwards value bytes with byte enables. It also produces the tag/body status that the detector receives on its `tag_status_i`/`body_status_i` inputs.

---
 rtl/fix_field_extractor_if.sv | 50 +++++
 rtl/fix_field_extractor.sv | 192 +++++++++++++++++++
 tb/tb_fix_field_extractor.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fix_field_extractor_if.sv
// Stream-in / field-out bundle for fix_field_extractor.
// The checksum pulses exist only when FIX_CHECKSUM_EN is defined.
interface fix_field_extractor_if #(
    parameter int unsigned TAG_W = 16,
    parameter int unsigned LEN_W = 12
);
    logic             valid_i;
    logic [31:0]      data_i;
    logic [2:0]       soh_i;
    logic [2:0]       sep_i;
    logic             tag_status_o;
    logic             body_status_o;
    logic             val_valid_o;
    logic [31:0]      val_data_o;
    logic [3:0]       val_be_o;
    logic             val_last_o;
    logic             field_valid_o;
    logic [TAG_W-1:0] field_tag_o;
    logic [LEN_W-1:0] field_len_o;
    logic             msg_done_o;
    logic             err_o;
`ifdef FIX_CHECKSUM_EN
    logic             cksum_ok_o;
    logic             cksum_err_o;

    modport master (
        output valid_i, data_i, soh_i, sep_i,
        input  tag_status_o, body_status_o, val_valid_o, val_data_o, val_be_o, val_last_o,
        input  field_valid_o, field_tag_o, field_len_o, msg_done_o, err_o,
        input  cksum_ok_o, cksum_err_o
    );
    modport slave (
        input  valid_i, data_i, soh_i, sep_i,
        output tag_status_o, body_status_o, val_valid_o, val_data_o, val_be_o, val_last_o,
        output field_valid_o, field_tag_o, field_len_o, msg_done_o, err_o,
        output cksum_ok_o, cksum_err_o
    );
`else
    modport master (
        output valid_i, data_i, soh_i, sep_i,
        input  tag_status_o, body_status_o, val_valid_o, val_data_o, val_be_o, val_last_o,
        input  field_valid_o, field_tag_o, field_len_o, msg_done_o, err_o
    );
    modport slave (
        input  valid_i, data_i, soh_i, sep_i,
        output tag_status_o, body_status_o, val_valid_o, val_data_o, val_be_o, val_last_o,
        output field_valid_o, field_tag_o, field_len_o, msg_done_o, err_o
    );
`endif
endinterface

// File: rtl/fix_field_extractor.sv
// FIX tag/value field framer placed behind the SOH/'=' byte-delimiter detector.
// Checksum verification of the tag-10 field is compiled in with FIX_CHECKSUM_EN.
module fix_field_extractor #(
    parameter int unsigned TAG_W = 16,
    parameter int unsigned LEN_W = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    fix_field_extractor_if.slave bus
);
    typedef enum logic {
        ST_TAG,
        ST_VALUE
    } state_e;

    localparam logic [TAG_W-1:0] TAG_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_e           state_q, state_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             body_q, body_d;
    logic             val_valid_q, val_valid_d;
    logic [31:0]      val_data_q, val_data_d;
    logic [3:0]       val_be_q, val_be_d;
    logic             val_last_q, val_last_d;
    logic             field_valid_q, field_valid_d;
    logic [TAG_W-1:0] field_tag_q, field_tag_d;
    logic [LEN_W-1:0] field_len_q, field_len_d;
    logic             msg_done_q, msg_done_d;
    logic             err_q, err_d;
    logic [7:0]       byte_v;
    logic [TAG_W+3:0] tag_ext_v;
`ifdef FIX_CHECKSUM_EN
    logic [7:0]       sum_q, sum_d;
    logic [7:0]       snap_q, snap_d;
    logic [23:0]      digits_q, digits_d;
    logic             cksum_ok_q, cksum_ok_d;
    logic             cksum_err_q, cksum_err_d;

    function automatic logic [23:0] ascii3(input logic [7:0] v);
        return {8'h30 + v / 8'd100, 8'h30 + (v / 8'd10) % 8'd10, 8'h30 + v % 8'd10};
    endfunction
`endif

    // Walk the four lanes in wire order; each delimiter lane switches state mid-word.
    always_comb begin
        state_d       = state_q;
        tag_d         = tag_q;
        len_d         = len_q;
        body_d        = body_q;
        val_valid_d   = 1'b0;
        val_data_d    = '0;
        val_be_d      = '0;
        val_last_d    = 1'b0;
        field_valid_d = 1'b0;
        field_tag_d   = '0;
        field_len_d   = '0;
        msg_done_d    = 1'b0;
        err_d         = 1'b0;
        byte_v        = '0;
        tag_ext_v     = '0;
`ifdef FIX_CHECKSUM_EN
        sum_d         = sum_q;
        snap_d        = snap_q;
        digits_d      = digits_q;
        cksum_ok_d    = 1'b0;
        cksum_err_d   = 1'b0;
`endif
        if (bus.valid_i) begin
            for (int unsigned i = 0; i < 4; i++) begin
                byte_v = bus.data_i[8*i +: 8];
`ifdef FIX_CHECKSUM_EN
                sum_d = sum_d + byte_v;
`endif
                if (bus.soh_i == 3'(i)) begin
                    if (state_d == ST_VALUE) begin
                        field_valid_d = 1'b1;
                        val_last_d    = 1'b1;
                        field_tag_d   = tag_d;
                        field_len_d   = len_d;
                        if (tag_d == TAG_W'(9)) body_d = 1'b1;
                        if (tag_d == TAG_W'(10)) begin
                            body_d     = 1'b0;
                            msg_done_d = 1'b1;
`ifdef FIX_CHECKSUM_EN
                            // snap_d still holds the sum at the SOH that preceded "10="
                            if (len_d == LEN_W'(3) && digits_d == ascii3(snap_d)) cksum_ok_d = 1'b1;
                            else cksum_err_d = 1'b1;
                            sum_d = '0;
`endif
                        end
                    end else begin
                        err_d = 1'b1;
                    end
`ifdef FIX_CHECKSUM_EN
                    snap_d = sum_d;
`endif
                    state_d = ST_TAG;
                    tag_d   = '0;
                end else if (bus.sep_i == 3'(i) && state_d == ST_TAG) begin
                    state_d = ST_VALUE;
                    len_d   = '0;
`ifdef FIX_CHECKSUM_EN
                    digits_d = '0;
`endif
                end else if (state_d == ST_VALUE) begin
                    val_be_d[i]           = 1'b1;
                    val_data_d[8*i +: 8]  = byte_v;
                    if (bus.sep_i == 3'(i)) err_d = 1'b1;
                    if (len_d != LEN_MAX) len_d = len_d + LEN_W'(1);
`ifdef FIX_CHECKSUM_EN
                    digits_d = {digits_d[15:0], byte_v};
`endif
                end else if (byte_v < 8'h30 || byte_v > 8'h39) begin
                    err_d = 1'b1;
                end else begin
                    tag_ext_v = {4'b0, tag_d} * (TAG_W + 4)'(10) + (TAG_W + 4)'(byte_v - 8'h30);
                    if (tag_ext_v > {4'b0, TAG_MAX}) begin
                        tag_d = TAG_MAX;
                        err_d = 1'b1;
                    end else begin
                        tag_d = tag_ext_v[TAG_W-1:0];
                    end
                end
            end
            val_valid_d = (|val_be_d) | field_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_TAG;
            tag_q         <= '0;
            len_q         <= '0;
            body_q        <= 1'b0;
            val_valid_q   <= 1'b0;
            val_data_q    <= '0;
            val_be_q      <= '0;
            val_last_q    <= 1'b0;
            field_valid_q <= 1'b0;
            field_tag_q   <= '0;
            field_len_q   <= '0;
            msg_done_q    <= 1'b0;
            err_q         <= 1'b0;
`ifdef FIX_CHECKSUM_EN
            sum_q         <= '0;
            snap_q        <= '0;
            digits_q      <= '0;
            cksum_ok_q    <= 1'b0;
            cksum_err_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            tag_q         <= tag_d;
            len_q         <= len_d;
            body_q        <= body_d;
            val_valid_q   <= val_valid_d;
            val_data_q    <= val_data_d;
            val_be_q      <= val_be_d;
            val_last_q    <= val_last_d;
            field_valid_q <= field_valid_d;
            field_tag_q   <= field_tag_d;
            field_len_q   <= field_len_d;
            msg_done_q    <= msg_done_d;
            err_q         <= err_d;
`ifdef FIX_CHECKSUM_EN
            sum_q         <= sum_d;
            snap_q        <= snap_d;
            digits_q      <= digits_d;
            cksum_ok_q    <= cksum_ok_d;
            cksum_err_q   <= cksum_err_d;
`endif
        end
    end

    assign bus.tag_status_o  = (state_q == ST_TAG);
    assign bus.body_status_o = body_q;
    assign bus.val_valid_o   = val_valid_q;
    assign bus.val_data_o    = val_data_q;
    assign bus.val_be_o      = val_be_q;
    assign bus.val_last_o    = val_last_q;
    assign bus.field_valid_o = field_valid_q;
    assign bus.field_tag_o   = field_tag_q;
    assign bus.field_len_o   = field_len_q;
    assign bus.msg_done_o    = msg_done_q;
    assign bus.err_o         = err_q;
`ifdef FIX_CHECKSUM_EN
    assign bus.cksum_ok_o    = cksum_ok_q;
    assign bus.cksum_err_o   = cksum_err_q;
`endif
endmodule

// File: tb/tb_fix_field_extractor.sv
// Bench for fix_field_extractor: FIX messages are generated as annotated byte streams
// (kind and error per byte, expected field records) and replayed word by word.
module tb_fix_field_extractor;
    localparam int unsigned TAG_W = 16;
    localparam int unsigned LEN_W = 12;
    localparam int TAG_LIM = 65535;
    localparam int LEN_LIM = 4095;
    localparam int K_TAG = 0;
    localparam int K_EQ  = 1;
    localparam int K_VAL = 2;
    localparam int K_SOH = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fix_field_extractor_if #(.TAG_W(TAG_W), .LEN_W(LEN_W)) bus ();
    fix_field_extractor #(.TAG_W(TAG_W), .LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] q_byte[$];
    int         q_kind[$];
    bit         q_err[$];
    int         f_tag[$];
    int         f_len[$];
    int         f_ck[$];
    int         gen_carry;
    bit         exp_body;
    bit         exp_tag_state;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    task automatic emit_byte(input logic [7:0] b, input int kind, input bit err);
        q_byte.push_back(b);
        q_kind.push_back(kind);
        q_err.push_back(err);
        gen_carry = (gen_carry + int'(b)) % 256;
    endtask

    // ck: 0 = no checksum result expected, 1 = ok, 2 = error
    task automatic emit_field(input string t, input string v, input int ck);
        int tv;
        bit e;
        logic [7:0] c;
        tv = 0;
        for (int i = 0; i < t.len(); i++) begin
            c = t[i];
            e = 1'b0;
            if (c < 8'h30 || c > 8'h39) e = 1'b1;
            else begin
                tv = tv * 10 + int'(c - 8'h30);
                if (tv > TAG_LIM) begin
                    tv = TAG_LIM;
                    e  = 1'b1;
                end
            end
            emit_byte(c, K_TAG, e);
        end
        emit_byte(8'h3D, K_EQ, 1'b0);
        for (int i = 0; i < v.len(); i++) begin
            c = v[i];
            emit_byte(c, K_VAL, c == 8'h3D);
        end
        emit_byte(8'h01, K_SOH, 1'b0);
        f_tag.push_back(tv);
        f_len.push_back(v.len() > LEN_LIM ? LEN_LIM : v.len());
        f_ck.push_back(ck);
        if (tv == 10) gen_carry = 0;
    endtask

    function automatic string rand_value(input int n);
        string v;
        int c;
        v = "";
        for (int i = 0; i < n; i++) begin
            c = $urandom_range(33, 126);
            if (c == 61) c = 62;
            v = $sformatf("%s%c", v, c);
        end
        return v;
    endfunction

    task automatic add_msg(input bit corrupt, input int nbody);
        string tg[$];
        string vl[$];
        int bl;
        int ck;
        tg.push_back("35");
        vl.push_back(corrupt ? "1" : "0");
        for (int k = 0; k < nbody; k++) begin
            string t;
            t = $sformatf("%0d", $urandom_range(11, 999));
            if ($urandom_range(0, 5) == 0) t = {t, "x"};
            if ($urandom_range(0, 9) == 0) t = "99999";
            tg.push_back(t);
            vl.push_back(rand_value($urandom_range(1, 7)));
        end
        bl = 0;
        foreach (tg[k]) bl += tg[k].len() + vl[k].len() + 2;
        emit_field("8", "FIX.4.2", 0);
        emit_field("9", $sformatf("%0d", bl), 0);
        foreach (tg[k]) emit_field(tg[k], vl[k], 0);
        // the clean body has '0' where the corrupted one has '1'
        ck = corrupt ? (gen_carry + 255) % 256 : gen_carry;
        emit_field("10", $sformatf("%03d", ck), corrupt ? 2 : 1);
    endtask

    task automatic align_stream();
        int r;
        r = q_byte.size() % 4;
        if (r != 0) emit_field("1", rand_value(5 - r), 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_val_valid"}, bus.val_valid_o, 0);
        check({tag, "_field_valid"}, bus.field_valid_o, 0);
        check({tag, "_msg_done"}, bus.msg_done_o, 0);
        check({tag, "_err"}, bus.err_o, 0);
        check({tag, "_tag_status"}, bus.tag_status_o, exp_tag_state);
        check({tag, "_body_status"}, bus.body_status_o, exp_body);
    endtask

    task automatic run_words(input int gap);
        logic [31:0] w;
        logic [2:0]  s, e;
        logic [3:0]  be;
        bit          done, err;
        int          ft, fl, fc, g;
        while (q_byte.size() >= 4) begin
            s = 3'd7; e = 3'd7; be = '0; done = 1'b0; err = 1'b0; w = '0;
            for (int i = 0; i < 4; i++) begin
                w[8*i +: 8] = q_byte[0];
                if (q_byte[0] == 8'h01 && s == 3'd7) s = 3'(i);
                if (q_byte[0] == 8'h3D && e == 3'd7) e = 3'(i);
                if (q_kind[0] == K_VAL) be[i] = 1'b1;
                if (q_kind[0] == K_SOH) done = 1'b1;
                err = err | q_err[0];
                exp_tag_state = (q_kind[0] == K_TAG || q_kind[0] == K_SOH);
                void'(q_byte.pop_front());
                void'(q_kind.pop_front());
                void'(q_err.pop_front());
            end
            bus.valid_i = 1'b1; bus.data_i = w; bus.soh_i = s; bus.sep_i = e;
            @(posedge clk);
            @(negedge clk);
            bus.valid_i = 1'b0;
            ft = 0; fl = 0; fc = 0;
            if (done) begin
                ft = f_tag.pop_front();
                fl = f_len.pop_front();
                fc = f_ck.pop_front();
                if (ft == 9) exp_body = 1'b1;
                if (ft == 10) exp_body = 1'b0;
            end
            check("val_valid", bus.val_valid_o, (be != 0) || done);
            check("val_be", bus.val_be_o, be);
            check("val_data", bus.val_data_o & lane_mask(be), w & lane_mask(be));
            check("val_last", bus.val_last_o, done);
            check("field_valid", bus.field_valid_o, done);
            check("err", bus.err_o, err);
            check("msg_done", bus.msg_done_o, done && ft == 10);
            check("tag_status", bus.tag_status_o, exp_tag_state);
            check("body_status", bus.body_status_o, exp_body);
            if (done) begin
                check("field_tag", bus.field_tag_o, ft);
                check("field_len", bus.field_len_o, fl);
            end
`ifdef FIX_CHECKSUM_EN
            check("cksum_ok", bus.cksum_ok_o, fc == 1);
            check("cksum_err", bus.cksum_err_o, fc == 2);
`endif
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int k = 0; k < g; k++) begin
                @(posedge clk);
                @(negedge clk);
                check_idle("gap");
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_val_valid"}, bus.val_valid_o, 0);
        check({tag, "_val_data"}, bus.val_data_o, 0);
        check({tag, "_val_be"}, bus.val_be_o, 0);
        check({tag, "_val_last"}, bus.val_last_o, 0);
        check({tag, "_field_valid"}, bus.field_valid_o, 0);
        check({tag, "_field_tag"}, bus.field_tag_o, 0);
        check({tag, "_field_len"}, bus.field_len_o, 0);
        check({tag, "_msg_done"}, bus.msg_done_o, 0);
        check({tag, "_err"}, bus.err_o, 0);
        check({tag, "_body_status"}, bus.body_status_o, 0);
        check({tag, "_tag_status"}, bus.tag_status_o, 1);
`ifdef FIX_CHECKSUM_EN
        check({tag, "_cksum_ok"}, bus.cksum_ok_o, 0);
        check({tag, "_cksum_err"}, bus.cksum_err_o, 0);
`endif
    endtask

    initial begin
        string lv;
        string t;
        int    l;
        rst = 1'b1;
        bus.valid_i = 1'b0; bus.data_i = '0; bus.soh_i = 3'd7; bus.sep_i = 3'd7;
        gen_carry = 0; exp_body = 1'b0; exp_tag_state = 1'b1;
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        // "8=FI" "X.4<SOH>" ; "35=A" "<SOH>49=" ; "3x=1<SOH>" split across words
        emit_field("8", "FIX.4", 0);
        emit_field("35", "A", 0);
        emit_field("49", "xy", 0);
        emit_field("3x", "1", 0);
        // tag and length saturation boundaries
        emit_field("65535", "q", 0);
        emit_field("65536", "q", 0);
        emit_field("99999", "qq", 0);
        lv = "";
        for (int i = 0; i < 4100; i++) lv = {lv, "a"};
        emit_field("12", lv, 0);
        // '=' inside a value, placed at lane 1 of a value-only word
        l = (3 - (q_byte.size() % 4) + 4) % 4;
        if (l == 0) l = 4;
        t = "";
        for (int i = 1; i < l; i++) t = {t, "1"};
        t = {t, "7"};
        emit_field(t, "a=bc", 0);
        add_msg(1'b0, 0);
        add_msg(1'b1, 0);
        run_words(0);

        repeat (10) begin
            add_msg(1'($urandom_range(0, 1)), $urandom_range(0, 3));
            run_words(-1);
        end
        add_msg(1'b0, 2);
        run_words(3);

        // reset in the middle of a value
        align_stream();
        run_words(0);
        emit_field("9", "5", 0);
        emit_byte(8'h37, K_TAG, 1'b0);
        emit_byte(8'h37, K_TAG, 1'b0);
        emit_byte(8'h3D, K_EQ, 1'b0);
        emit_byte(8'h61, K_VAL, 1'b0);
        run_words(0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state("midrst");
        rst = 1'b0;
        gen_carry = 0; exp_body = 1'b0; exp_tag_state = 1'b1;
        emit_field("52", "1", 0);
        add_msg(1'b0, 1);
        align_stream();
        run_words(-1);
        check("fields_consumed", f_tag.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
